// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   A winning producer owns the port for a burst of up to MAX_BURST beats;
//   the next arbitration starts searching just above the previous owner, so
//   ownership rotates fairly. One IDLE cycle separates consecutive bursts.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_req_valid    per-producer valid
//   i_req_data     producer i data on [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready    one-hot/zero accept strobe toward the producers
//   i_fifo_full    FIFO full flag
//   o_fifo_wren    FIFO write enable
//   o_fifo_wdata   FIFO write data (owner's slice, zero outside a burst)
//   o_grant_id     current or most recent owner
//   o_busy         high while a burst is in progress
// ---------------------------------------------------------------------------

// Per-producer slice: qualifies ready and data with ownership.
module fifo_wr_arbiter_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_sel,
    input  logic                  i_busy,
    input  logic                  i_fifo_full,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic w_own;

    assign w_own   = i_sel & i_busy;
    assign o_ready = w_own & ~i_fifo_full;
    // AND-OR mux contribution; non-owners contribute zero.
    assign o_data  = w_own ? i_data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_wren,
    output logic [DATA_WIDTH-1:0]         o_fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                r_state, w_next_state;
    logic [ID_W-1:0]       r_owner, w_next_owner;
    logic [ID_W-1:0]       r_last_grant, w_next_last;
    logic [CNT_W-1:0]      r_beat_cnt, w_next_cnt;

    logic                  w_busy;
    logic [NUM_REQ-1:0]    w_own_oh;
    logic                  w_owner_valid;
    logic                  w_write;
    logic                  w_found;
    logic [ID_W-1:0]       w_winner;
    logic [ID_W-1:0]       w_idx;
    logic [NUM_REQ-1:0]    w_lane_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_lane_data;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_busy = (r_state == BURST);

    // Owner decode feeds the lanes; only the owner's valid reaches wren.
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            assign w_own_oh[g] = (r_owner == ID_W'(g));

            fifo_wr_arbiter_lane #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .i_sel       (w_own_oh[g]),
                .i_busy      (w_busy),
                .i_fifo_full (i_fifo_full),
                .i_data      (i_req_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .o_ready     (w_lane_ready[g]),
                .o_data      (w_lane_data[g])
            );
        end
    endgenerate

    always_comb begin
        w_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_wdata = w_wdata | w_lane_data[k];
        end
    end

    assign w_owner_valid = |(i_req_valid & w_own_oh);
    assign w_write       = w_busy & w_owner_valid & ~i_fifo_full;

    // Rotating priority search: first valid index strictly above the
    // previous grant, wrapping, so the previous owner is checked last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_last  = r_last_grant;
        w_next_cnt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_found && !i_fifo_full) begin
                    w_next_state = BURST;
                    w_next_owner = w_winner;
                    w_next_last  = w_winner;
                    w_next_cnt   = '0;
                end
            end
            BURST: begin
                // Release by the owner takes priority; a stall (full with
                // owner valid) simply holds everything.
                if (!w_owner_valid) begin
                    w_next_state = IDLE;
                end else if (w_write) begin
                    w_next_cnt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_last_grant <= w_next_last;
            r_beat_cnt   <= w_next_cnt;
        end
    end

    assign o_req_ready  = w_lane_ready;
    assign o_fifo_wren  = w_write;
    assign o_fifo_wdata = w_wdata;
    assign o_grant_id   = r_owner;
    assign o_busy       = w_busy;

endmodule
